vga_scanout: RTL and testbench
==============================

# vga_scanout

Scan-out stage between the DLX framebuffer memory and the DE1-SoC VGA DAC pins. Generates 640x480@60 Hz timing from `clock_50` with a divide-by-2 pixel enable. Fetches one RGB332 pixel per active pixel from the framebuffer read port and drives `VGA_*` with sync and blank aligned to the pixel data. Instantiated in `DE1_SoC`; its outputs go directly to the top-level VGA ports.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal porches and sync, in pixels
- `V_ACTIVE`, 480: visible lines
- `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical porches and sync, in lines
- `ADDR_W`, 19: framebuffer address width, holding at least H_ACTIVE*V_ACTIVE

Ports:
- `clock_50`  in  1  system clock, 50 MHz
- `reset`  in  1  synchronous, active-high reset
- `fb_rd`  out  1  framebuffer read strobe
- `fb_addr`  out  ADDR_W  linear pixel address, y*H_ACTIVE+x
- `fb_data`  in  8  RGB332 pixel; valid the clock after `fb_rd`
- `frame_start`  out  1  one-clock pulse at pixel (0,0)
- `VGA_CLK`  out  1  25 MHz pixel clock to the DAC
- `VGA_HS`, `VGA_VS`  out  1  syncs, active low
- `VGA_BLANK`  out  1  active-low blank
- `VGA_SYNC`  out  1  tied 0
- `VGA_R`, `VGA_G`, `VGA_B`  out  8  colour channels

## Operation
- `pe` toggles every clock: it is 0 in the first clock after reset release and 1 in the next.
- `h_cnt` counts 0..799 and `v_cnt` counts 0..524. Both advance only when `pe`=1.
  - `h_cnt` wraps to 0 and increments `v_cnt`.
  - `v_cnt` wraps to 0 after (799,524).
- Active region: `h_cnt`<640 and `v_cnt`<480.
- Fetch stage (`pe`=1, counters at (h,v)):
  - In the active region: `fb_rd`=1 for exactly that clock, with `fb_addr`=v*640+h.
  - Otherwise: `fb_rd`=0 and `fb_addr` holds its value.
- Address generation is incremental, with no multiplier:
  - +1 per active pixel.
  - Reset to 0 at (799,524).
  - No adjustment at the line end, because active pixels are contiguous in linear order.
- Output stage, at the next `pe`=1:
  - Register the RGB expansion of `fb_data`, which was captured in the `pe`=0 clock.
  - Register HS, VS and BLANK computed from the previous pixel's counters, so all outputs carry equal one-pixel latency.
- Sync pulses:
  - `VGA_HS`=0 for `h_cnt` 656..751.
  - `VGA_VS`=0 for `v_cnt` 490..491.
  - `VGA_BLANK`=1 only in the active region.
- Outside the active region R/G/B are forced to 0.
- RGB332 expansion:
  - R={d[7:5],d[7:5],d[7:6]}
  - G={d[4:2],d[4:2],d[4:3]}
  - B={d[1:0]x4}
- `frame_start`=1 for the single clock where `pe`=1 and counters=(0,0).

## Timing
- Reset values: counters 0, `pe`=0, `fb_rd`=0, `fb_addr`=0, `frame_start`=0, `VGA_CLK`=0, `VGA_HS`=1, `VGA_VS`=1, `VGA_BLANK`=0, R/G/B=0, `VGA_SYNC`=0.
- `VGA_CLK` is a register equal to ~`pe`. Its rising edge lands mid-way through each output pixel's two-clock hold.
- Latency: counters at (h,v) with `pe`=1 produce the pixel on `VGA_R/G/B` 2 clocks later, held for 2 clocks.
- Line period: 1600 clocks. Frame period: 840000 clocks.
- Reset asserted mid-frame: all state returns to reset values in the next clock. Scan restarts at (0,0), and `frame_start` fires on the first `pe`=1 after release.
- `fb_data` is ignored in every clock except the one after `fb_rd`.

## Structure
- Package `vga_pkg`:
  - 640x480 timing constants
  - derived `H_TOTAL`=800 and `V_TOTAL`=525
  - function `rgb332_to_rgb888`
- Sub-module `vga_sync_counter`: `pe`, `h_cnt`/`v_cnt`, active/hsync/vsync decode.
- `vga_scanout`: address generator, fetch/output pipeline, output registers.

## Test plan
- Reset held 5 clocks, then released -> every output at its reset value during reset. First `fb_rd`=1 with `fb_addr`=0 on the second clock after release.
- Free run for one line -> `fb_rd` pulses 640 times with addresses 0..639. `VGA_HS` low for exactly 192 clocks, starting 1312+2 clocks after the first fetch. Second line starts at `fb_addr`=640.
- Full frame -> `VGA_VS` low for 3200 clocks. `frame_start` pulses are 840000 clocks apart. `fb_addr` returns to 0 after 307199.
- `fb_data`=0xE0 constant -> R=0xFF, G=0x00, B=0x00 during active pixels. `fb_data`=0x03 -> B=0xFF. All channels 0 while `VGA_BLANK`=0.
- Reset pulsed at `v_cnt`=200, `h_cnt`=300 -> next fetch after release has `fb_addr`=0. `VGA_HS`/`VGA_VS` high immediately.
- Bench drives `fb_data`=X except the clock after `fb_rd` -> no X on `VGA_R/G/B` at any time.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and the RGB332 to RGB888 colour expansion
// used by the VGA scan-out stage.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int FB_ADDR_W = 19;

  // Bit replication spreads each channel over the full 0..255 range.
  function automatic logic [23:0] rgb332_to_rgb888(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6],
            d[4:2], d[4:2], d[4:3],
            {4{d[1:0]}}};
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-enable generator and horizontal/vertical raster counters with the
// active-region and sync decodes for the current pixel position.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1)
) (
  input  logic clk,
  input  logic reset,
  output logic pe,
  output logic active,
  output logic hsync_n,
  output logic vsync_n,
  output logic origin,
  output logic frame_end
);

  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pe    <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      pe <= ~pe;
      if (pe) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync_n   = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vsync_n   = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    origin    = (h_cnt == '0) && (v_cnt == '0);
    frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  end

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scan-out: fetches one RGB332 pixel per active position and drives
// the VGA DAC with colour, sync and blank all carrying the same pipeline delay.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int ADDR_W   = FB_ADDR_W
) (
  input  logic              clock_50,
  input  logic              reset,
  output logic              fb_rd,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic              frame_start,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK,
  output logic              VGA_SYNC,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B
);

  logic pe, active, hsync_n, vsync_n, origin, frame_end;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_sync (
    .clk       (clock_50),
    .reset     (reset),
    .pe        (pe),
    .active    (active),
    .hsync_n   (hsync_n),
    .vsync_n   (vsync_n),
    .origin    (origin),
    .frame_end (frame_end)
  );

  // Active pixels are contiguous in linear order, so a running count is the address.
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      addr_q <= '0;
    end else if (pe) begin
      if (frame_end)   addr_q <= '0;
      else if (active) addr_q <= addr_q + 1'b1;
    end
  end

  assign fb_rd       = pe & active;
  assign fb_addr     = addr_q;
  assign frame_start = pe & origin;
  assign VGA_SYNC    = 1'b0;

  // Decodes of the fetched pixel, held until its data returns a clock later.
  logic active_d, hs_d, vs_d;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      active_d <= 1'b0;
      hs_d     <= 1'b1;
      vs_d     <= 1'b1;
    end else if (pe) begin
      active_d <= active;
      hs_d     <= hsync_n;
      vs_d     <= vsync_n;
    end
  end

  logic [23:0] pixel;
  assign pixel = rgb332_to_rgb888(fb_data);

  // Outputs update at the end of the pe=0 clock, when fb_data carries the fetch.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      VGA_CLK   <= 1'b0;
      VGA_HS    <= 1'b1;
      VGA_VS    <= 1'b1;
      VGA_BLANK <= 1'b0;
      VGA_R     <= 8'h00;
      VGA_G     <= 8'h00;
      VGA_B     <= 8'h00;
    end else begin
      VGA_CLK <= pe;
      if (!pe) begin
        VGA_HS    <= hs_d;
        VGA_VS    <= vs_d;
        VGA_BLANK <= active_d;
        {VGA_R, VGA_G, VGA_B} <= active_d ? pixel : 24'h000000;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size instance for line-level timing and a
// shrunken-raster instance for frame wrap and mid-frame reset behaviour.
module tb_vga_scanout;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp;
  } tim_t;

  typedef struct packed {
    logic        fb_rd;
    logic [18:0] fb_addr;
    logic        frame_start;
    logic        vga_clk;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        sync;
    logic [23:0] rgb;
  } exp_t;

  localparam int EW = $bits(exp_t);

  tim_t tim_b = '{640, 16, 96, 48, 480, 10, 2, 33};
  tim_t tim_s = '{8, 2, 3, 2, 4, 1, 2, 1};

  // ---------------- clock / reset ----------------
  logic clock_50 = 1'b0;
  logic reset = 1'b1;
  always #5 clock_50 = ~clock_50;

  // ---------------- DUT signals ----------------
  logic        fb_rd_b, frame_start_b, vclk_b, hs_b, vs_b, blank_b, sync_b;
  logic [18:0] fb_addr_b;
  logic [7:0]  fb_data_b, r_b, g_b, b_b;
  logic        fb_rd_s, frame_start_s, vclk_s, hs_s, vs_s, blank_s, sync_s;
  logic [5:0]  fb_addr_s;
  logic [7:0]  fb_data_s, r_s, g_s, b_s;

  vga_scanout u_big (
    .clock_50 (clock_50), .reset (reset),
    .fb_rd (fb_rd_b), .fb_addr (fb_addr_b), .fb_data (fb_data_b),
    .frame_start (frame_start_b), .VGA_CLK (vclk_b),
    .VGA_HS (hs_b), .VGA_VS (vs_b), .VGA_BLANK (blank_b), .VGA_SYNC (sync_b),
    .VGA_R (r_b), .VGA_G (g_b), .VGA_B (b_b)
  );

  vga_scanout #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .ADDR_W (6)
  ) u_small (
    .clock_50 (clock_50), .reset (reset),
    .fb_rd (fb_rd_s), .fb_addr (fb_addr_s), .fb_data (fb_data_s),
    .frame_start (frame_start_s), .VGA_CLK (vclk_s),
    .VGA_HS (hs_s), .VGA_VS (vs_s), .VGA_BLANK (blank_s), .VGA_SYNC (sync_s),
    .VGA_R (r_s), .VGA_G (g_s), .VGA_B (b_s)
  );

  // ---------------- reference model ----------------
  int k = 0;  // clocks since the last edge that sampled reset high
  int n_vec = 0;
  int n_miss = 0;
  logic [7:0] hist_b [8];
  logic [7:0] hist_s [8];
  logic prev_rd_b = 1'b0;
  logic prev_rd_s = 1'b0;
  logic [EW-1:0] exp_q_b[$];
  logic [EW-1:0] exp_q_s[$];

  function automatic logic [23:0] exp_rgb(input logic [7:0] d);
    int r, g, b;
    r = (int'(d[7:5]) * 255 + 3) / 7;
    g = (int'(d[4:2]) * 255 + 3) / 7;
    b = int'(d[1:0]) * 85;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  // Expected outputs for clock k, from raster arithmetic on the pixel index.
  function automatic logic [EW-1:0] model(input tim_t t, input int kk, input logic [7:0] hist [8]);
    exp_t e;
    int ht, vt, n, h, v, a, f, hf, vf;
    logic act;
    ht = t.ha + t.hfp + t.hs + t.hbp;
    vt = t.va + t.vfp + t.vs + t.vbp;
    n = kk / 2;
    h = n % ht;
    v = (n / ht) % vt;
    if (v < t.va) a = v * t.ha + ((h < t.ha) ? h : t.ha);
    else          a = t.va * t.ha;
    e.fb_rd       = (kk % 2 == 1) && (h < t.ha) && (v < t.va);
    e.fb_addr     = 19'(a);
    e.frame_start = (kk % 2 == 1) && (n % (ht * vt) == 0);
    e.vga_clk     = (kk >= 1) && (kk % 2 == 0);
    e.sync        = 1'b0;
    if (kk < 3) begin
      e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0; e.rgb = 24'h0;
    end else begin
      f  = ((kk - 2) % 2 == 1) ? kk - 2 : kk - 3;
      hf = (f / 2) % ht;
      vf = ((f / 2) / ht) % vt;
      act     = (hf < t.ha) && (vf < t.va);
      e.hs    = !((hf >= t.ha + t.hfp) && (hf < t.ha + t.hfp + t.hs));
      e.vs    = !((vf >= t.va + t.vfp) && (vf < t.va + t.vfp + t.vs));
      e.blank = act;
      e.rgb   = act ? exp_rgb(hist[(f + 1) % 8]) : 24'h0;
    end
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s k=%0d got=%h want=%h", name, k, got, want);
    end
  endtask

  task automatic check_vec(input string inst, input logic [EW-1:0] ev, input logic [EW-1:0] av);
    exp_t e, a;
    e = ev;
    a = av;
    cmp({inst, ".fb_rd"},       32'(a.fb_rd),       32'(e.fb_rd));
    cmp({inst, ".fb_addr"},     32'(a.fb_addr),     32'(e.fb_addr));
    cmp({inst, ".frame_start"}, 32'(a.frame_start), 32'(e.frame_start));
    cmp({inst, ".vga_clk"},     32'(a.vga_clk),     32'(e.vga_clk));
    cmp({inst, ".hs"},          32'(a.hs),          32'(e.hs));
    cmp({inst, ".vs"},          32'(a.vs),          32'(e.vs));
    cmp({inst, ".blank"},       32'(a.blank),       32'(e.blank));
    cmp({inst, ".sync"},        32'(a.sync),        32'(e.sync));
    cmp({inst, ".rgb"},         32'(a.rgb),         32'(e.rgb));
  endtask

  always @(negedge clock_50) begin
    if (exp_q_b.size() > 0)
      check_vec("big", exp_q_b.pop_front(),
        {fb_rd_b, fb_addr_b, frame_start_b, vclk_b, hs_b, vs_b, blank_b, sync_b, r_b, g_b, b_b});
    if (exp_q_s.size() > 0)
      check_vec("small", exp_q_s.pop_front(),
        {fb_rd_s, 13'b0, fb_addr_s, frame_start_s, vclk_s, hs_s, vs_s, blank_s, sync_s, r_s, g_s, b_s});
  end

  // ---------------- driver ----------------
  // One clock: update the model position, drive reset/fb_data, queue expectations.
  task automatic step(input logic rst);
    exp_t eb, es;
    int vp;
    @(posedge clock_50);
    if (reset) k = 0;
    else       k++;
    #1;
    reset = rst;
    vp = (((k - 1) / 2) / 800) % 525;
    if (prev_rd_b && k != 0)
      fb_data_b = (vp == 0) ? 8'hE0 : (vp == 1) ? 8'h03 : 8'($urandom_range(0, 255));
    else
      fb_data_b = 8'hxx;
    fb_data_s = (prev_rd_s && k != 0) ? 8'($urandom_range(0, 255)) : 8'hxx;
    hist_b[k % 8] = fb_data_b;
    hist_s[k % 8] = fb_data_s;
    eb = model(tim_b, k, hist_b);
    es = model(tim_s, k, hist_s);
    exp_q_b.push_back(eb);
    exp_q_s.push_back(es);
    prev_rd_b = eb.fb_rd;
    prev_rd_s = es.fb_rd;
    @(negedge clock_50);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int hs_first, hs_low, vs_low, fs_first, fs_gap;
    fb_data_b = 8'hxx;
    fb_data_s = 8'hxx;
    hs_first = -1; hs_low = 0; vs_low = 0; fs_first = -1; fs_gap = -1;

    repeat (5) step(1'b1);
    cmp("rst.hs", 32'(hs_b), 32'd1);
    cmp("rst.vs", 32'(vs_b), 32'd1);
    cmp("rst.blank", 32'(blank_b), 32'd0);
    cmp("rst.rgb", 32'({r_b, g_b, b_b}), 32'd0);
    cmp("rst.fb_rd", 32'(fb_rd_b), 32'd0);
    cmp("rst.vga_clk", 32'(vclk_b), 32'd0);

    // Free run from release: first line of the big raster, frames of the small one.
    repeat (1700) begin
      step(1'b0);
      if (k == 1) begin
        cmp("first.fb_rd", 32'(fb_rd_b), 32'd1);
        cmp("first.fb_addr", 32'(fb_addr_b), 32'd0);
        cmp("first.frame_start", 32'(frame_start_b), 32'd1);
      end
      if (k == 3) begin
        cmp("e0.r", 32'(r_b), 32'hFF);
        cmp("e0.g", 32'(g_b), 32'h00);
        cmp("e0.b", 32'(b_b), 32'h00);
        cmp("e0.blank", 32'(blank_b), 32'd1);
      end
      if (k == 1601) begin
        cmp("line1.fb_rd", 32'(fb_rd_b), 32'd1);
        cmp("line1.fb_addr", 32'(fb_addr_b), 32'd640);
      end
      if (k == 1603) begin
        cmp("03.b", 32'(b_b), 32'hFF);
        cmp("03.r", 32'(r_b), 32'h00);
      end
      if (k == 239) cmp("small.last_addr", 32'(fb_addr_s), 32'd32);
      if (k == 241) begin
        cmp("small.wrap_rd", 32'(fb_rd_s), 32'd1);
        cmp("small.wrap_addr", 32'(fb_addr_s), 32'd0);
      end
      if (k < 1600 && hs_b === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (k >= 1 && k < 241 && vs_s === 1'b0) vs_low++;
      if (frame_start_s === 1'b1) begin
        if (fs_first < 0) fs_first = k;
        else if (fs_gap < 0) fs_gap = k - fs_first;
      end
    end
    cmp("hs.first", 32'(hs_first), 32'd1315);
    cmp("hs.low_clocks", 32'(hs_low), 32'd192);
    cmp("small.vs_low_clocks", 32'(vs_low), 32'd60);
    cmp("small.frame_gap", 32'(fs_gap), 32'd240);

    // Reset in mid-frame, small raster at h=5, v=3 with pe=1.
    while (k % 240 != 101) step(1'b0);
    step(1'b1);
    step(1'b0);
    cmp("midrst.hs", 32'(hs_s), 32'd1);
    cmp("midrst.vs", 32'(vs_s), 32'd1);
    step(1'b0);
    cmp("midrst.fb_addr_s", 32'(fb_addr_s), 32'd0);
    cmp("midrst.fb_addr_b", 32'(fb_addr_b), 32'd0);
    cmp("midrst.frame_start", 32'(frame_start_s), 32'd1);

    // Randomly placed reset pulses of random length.
    repeat (4) begin
      repeat ($urandom_range(300, 1500)) step(1'b0);
      repeat ($urandom_range(1, 3)) step(1'b1);
    end
    repeat (2000) step(1'b0);

    @(posedge clock_50);
    @(negedge clock_50);
    cmp("queue.drained", 32'(exp_q_b.size() + exp_q_s.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
